// File: rtl/i2c_target_regfile.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_regfile
// Description : I2C target that answers one 7-bit address and serves an
//               internal register file. The first write byte loads the
//               register pointer, later write bytes store at the pointer
//               with auto-increment, and reads return data at the pointer
//               with auto-increment. A host-side read port and write-event
//               strobes expose the register file to the local side.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h22,
    parameter int         MEM_DEPTH   = 16,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_FILL  = 8'h00,
    localparam int        PTR_W       = $clog2(MEM_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe_o,
    output logic             busy_o,
    output logic             start_o,
    output logic             stop_o,
    output logic             wr_stb_o,
    output logic [PTR_W-1:0] wr_addr_o,
    output logic [7:0]       wr_data_o,
    output logic             addr_hit_o,
    input  logic [PTR_W-1:0] host_addr_i,
    output logic [7:0]       host_rdata_o
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RACK      = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;

    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    logic [3:0]       r_state;
    logic [2:0]       r_bit_cnt;
    logic [6:0]       r_shift;
    logic [7:0]       r_tx;
    logic [PTR_W-1:0] r_ptr;
    logic             r_rw;
    logic             r_master_nack;
    logic             r_sda_oe;
    logic             r_busy;
    logic             r_start;
    logic             r_stop;
    logic             r_wr_stb;
    logic [PTR_W-1:0] r_wr_addr;
    logic [7:0]       r_wr_data;
    logic             r_addr_hit;
    logic [7:0]       r_host_rdata;
    logic [7:0]       r_mem [MEM_DEPTH];

    logic       w_scl_s;
    logic       w_sda_s;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_rx_byte;
    logic [7:0] w_mem_ptr;
    logic       w_wr_en;

    // Bring both bus lines into the clock domain; idle bus level is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= w_sda_s;
        end
    end

    assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl_s & ~r_scl_d;
    assign w_scl_fall = ~w_scl_s & r_scl_d;
    assign w_start    = w_scl_s & r_sda_d & ~w_sda_s;
    assign w_stop     = w_scl_s & ~r_sda_d & w_sda_s;

    // Byte assembled from the seven bits already shifted plus the bit on the line.
    assign w_rx_byte  = {r_shift, w_sda_s};
    assign w_mem_ptr  = r_mem[r_ptr];

    // A data byte is committed only when its 8th bit is sampled without a bus condition.
    assign w_wr_en    = (r_state == S_WDATA) && w_scl_rise && (r_bit_cnt == 3'd0)
                        && !w_start && !w_stop;

    // Register file storage: refilled on reset, written by completed bus data bytes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= RESET_FILL;
            end
        end else if (w_wr_en) begin
            r_mem[r_ptr] <= w_rx_byte;
        end
    end

    // Host read port: registered, so a same-cycle bus write shows up one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_host_rdata <= 8'h00;
        end else begin
            r_host_rdata <= r_mem[host_addr_i];
        end
    end

    // Protocol engine; SDA drive only changes on the cycle after an SCL fall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= 3'd7;
            r_shift       <= 7'd0;
            r_tx          <= 8'h00;
            r_ptr         <= '0;
            r_rw          <= 1'b0;
            r_master_nack <= 1'b0;
            r_sda_oe      <= 1'b0;
            r_busy        <= 1'b0;
            r_start       <= 1'b0;
            r_stop        <= 1'b0;
            r_wr_stb      <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= 8'h00;
            r_addr_hit    <= 1'b0;
        end else begin
            r_start  <= 1'b0;
            r_stop   <= 1'b0;
            r_wr_stb <= 1'b0;
            if (w_start) begin
                // Pointer is deliberately kept so a read can follow a pointer write.
                r_state   <= S_ADDR;
                r_bit_cnt <= 3'd7;
                r_sda_oe  <= 1'b0;
                r_start   <= 1'b1;
                r_busy    <= 1'b1;
            end else if (w_stop) begin
                r_state    <= S_IDLE;
                r_sda_oe   <= 1'b0;
                r_stop     <= 1'b1;
                r_busy     <= 1'b0;
                r_addr_hit <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_rx_byte[6:0];
                            if (r_bit_cnt == 3'd0) begin
                                if (w_rx_byte[7:1] == TARGET_ADDR) begin
                                    r_state    <= S_ADDR_ACK;
                                    r_addr_hit <= 1'b1;
                                    r_rw       <= w_rx_byte[0];
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                            end
                        end
                    end
                    // First fall pulls SDA for the ACK, second fall ends the ACK clock.
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= 3'd7;
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else if (r_rw) begin
                                r_tx     <= w_mem_ptr;
                                r_sda_oe <= ~w_mem_ptr[7];
                                r_state  <= S_RDATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_PTR;
                            end
                        end
                    end
                    S_PTR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_rx_byte[6:0];
                            if (r_bit_cnt == 3'd0) begin
                                r_ptr   <= w_rx_byte[PTR_W-1:0];
                                r_state <= S_PTR_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                            end
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= 3'd7;
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_WDATA;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift <= w_rx_byte[6:0];
                            if (r_bit_cnt == 3'd0) begin
                                r_wr_stb  <= 1'b1;
                                r_wr_addr <= r_ptr;
                                r_wr_data <= w_rx_byte;
                                r_ptr     <= r_ptr + c_ptr_one;
                                r_state   <= S_WDATA_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd0) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_RACK;
                            end else begin
                                r_tx      <= {r_tx[6:0], 1'b0};
                                r_sda_oe  <= ~r_tx[6];
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                            end
                        end
                    end
                    // Pointer advances on the master's ACK bit whether it ACKs or NACKs.
                    S_RACK: begin
                        if (w_scl_rise) begin
                            r_master_nack <= w_sda_s;
                            r_ptr         <= r_ptr + c_ptr_one;
                        end else if (w_scl_fall) begin
                            r_bit_cnt <= 3'd7;
                            if (!r_master_nack) begin
                                r_tx     <= w_mem_ptr;
                                r_sda_oe <= ~w_mem_ptr[7];
                                r_state  <= S_RDATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_IGNORE;
                            end
                        end
                    end
                    S_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end
                    S_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_sda_oe <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sda_oe_o     = r_sda_oe;
    assign busy_o       = r_busy;
    assign start_o      = r_start;
    assign stop_o       = r_stop;
    assign wr_stb_o     = r_wr_stb;
    assign wr_addr_o    = r_wr_addr;
    assign wr_data_o    = r_wr_data;
    assign addr_hit_o   = r_addr_hit;
    assign host_rdata_o = r_host_rdata;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_target_regfile
// Description : Bus-master bench for i2c_target_regfile with a register-file
//               reference model, directed scenarios and random transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target_regfile;

    localparam logic [6:0] c_addr  = 7'h22;
    localparam int         c_depth = 16;
    localparam int         c_q     = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic [3:0] host_addr;

    logic       sda_oe;
    logic       busy;
    logic       start_p;
    logic       stop_p;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       addr_hit;
    logic [7:0] host_rdata;

    wire sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regfile #(
        .TARGET_ADDR (c_addr),
        .MEM_DEPTH   (c_depth),
        .SYNC_STAGES (2),
        .RESET_FILL  (8'h00)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .scl_i        (scl_m),
        .sda_i        (sda_bus),
        .sda_oe_o     (sda_oe),
        .busy_o       (busy),
        .start_o      (start_p),
        .stop_o       (stop_p),
        .wr_stb_o     (wr_stb),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .addr_hit_o   (addr_hit),
        .host_addr_i  (host_addr),
        .host_rdata_o (host_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;
    int stop_cnt  = 0;
    int oe_cnt    = 0;
    int oe_viol   = 0;
    int got_wr[$];
    int exp_wr[$];
    logic [7:0] model_mem [c_depth];
    int         model_ptr;
    logic [7:0] wbuf [8];
    logic prev_oe  = 1'b0;
    logic prev_scl = 1'b1;
    logic prev_rst = 1'b1;

    // Observe pulses, write events and SDA drive changes while SCL is high.
    always @(negedge clk) begin
        if (start_p) start_cnt++;
        if (stop_p) stop_cnt++;
        if (sda_oe) oe_cnt++;
        if (wr_stb) got_wr.push_back(int'(wr_addr) * 256 + int'(wr_data));
        if (!prev_rst && !rst && prev_scl && scl_m && (prev_oe !== sda_oe)) oe_viol++;
        prev_oe  = sda_oe;
        prev_scl = scl_m;
        prev_rst = rst;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic qwait();
        repeat (c_q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait(); qwait();
        sda_m = 1'b0; qwait(); qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait(); qwait();
        sda_m = 1'b1; qwait(); qwait();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; qwait();
        scl_m = 1'b1; qwait(); qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        b = sda_bus; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        for (int i = 7; i >= 0; i--) get_bit(d[i]);
        send_bit(nack);
    endtask

    function automatic void model_write(input logic [7:0] b);
        model_mem[model_ptr] = b;
        exp_wr.push_back(model_ptr * 256 + int'(b));
        model_ptr = (model_ptr + 1) % c_depth;
    endfunction

    task automatic check_wr();
        check("wr_count", got_wr.size(), exp_wr.size());
        for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
            check("wr_event", got_wr[i], exp_wr[i]);
        got_wr.delete();
        exp_wr.delete();
    endtask

    task automatic check_host(input int idx);
        host_addr = idx[3:0];
        @(negedge clk); @(negedge clk);
        check("host_rdata", host_rdata, model_mem[idx]);
    endtask

    task automatic read_body(input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            read_byte(d, (i == n - 1));
            check("rdata", d, model_mem[model_ptr]);
            model_ptr = (model_ptr + 1) % c_depth;
        end
    endtask

    task automatic t_write(input logic [6:0] a, input logic [7:0] p, input int n);
        logic ack;
        logic hit;
        hit = (a == c_addr);
        bus_start();
        write_byte({a, 1'b0}, ack); check("addr_ack", ack, !hit);
        write_byte(p, ack);         check("ptr_ack", ack, !hit);
        if (hit) model_ptr = p % c_depth;
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], ack); check("data_ack", ack, !hit);
            if (hit) model_write(wbuf[i]);
        end
        check("busy_mid", busy, 1'b1);
        check("hit_mid", addr_hit, hit);
        bus_stop();
        check("busy_end", busy, 1'b0);
        check("hit_end", addr_hit, 1'b0);
        check_wr();
    endtask

    task automatic t_ptr_read(input logic [7:0] p, input int n);
        logic ack;
        bus_start();
        write_byte({c_addr, 1'b0}, ack); check("addr_ack", ack, 1'b0);
        write_byte(p, ack);              check("ptr_ack", ack, 1'b0);
        model_ptr = p % c_depth;
        bus_start();
        write_byte({c_addr, 1'b1}, ack); check("raddr_ack", ack, 1'b0);
        read_body(n);
        bus_stop();
    endtask

    task automatic t_read(input int n);
        logic ack;
        bus_start();
        write_byte({c_addr, 1'b1}, ack); check("raddr_ack", ack, 1'b0);
        read_body(n);
        bus_stop();
    endtask

    initial begin
        int s0, p0, o0, n, kind;
        logic ack;
        logic b;
        logic [7:0] p;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; host_addr = 4'd0;
        for (int i = 0; i < c_depth; i++) model_mem[i] = 8'h00;
        model_ptr = 0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_start", start_p, 1'b0);
        check("rst_stop", stop_p, 1'b0);
        check("rst_wr_stb", wr_stb, 1'b0);
        check("rst_wr_addr", wr_addr, 4'd0);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_addr_hit", addr_hit, 1'b0);
        for (int i = 0; i < c_depth; i++) check_host(i);

        // Pointer 3, data A5 5A
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        t_write(c_addr, 8'h03, 2);
        check_host(3);
        check("host_a5", host_rdata, 8'hA5);

        // Pointer write, repeated START, two-byte read
        s0 = start_cnt; p0 = stop_cnt;
        t_ptr_read(8'h03, 2);
        check("start_pulses", start_cnt - s0, 2);
        check("stop_pulses", stop_cnt - p0, 1);

        // Foreign address is never acknowledged
        o0 = oe_cnt;
        wbuf[0] = 8'h12; wbuf[1] = 8'h34; wbuf[2] = 8'h56;
        t_write(7'h23, 8'h01, 3);
        check("foreign_oe", oe_cnt - o0, 0);

        // Pointer wrap and upper pointer bits ignored
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        t_write(c_addr, 8'h0F, 2);
        check_host(15);
        check_host(0);
        check("wrap_mem0", host_rdata, 8'h22);
        wbuf[0] = 8'h33;
        t_write(c_addr, 8'h1F, 1);
        check_host(15);
        check("ptr1f_mem15", host_rdata, 8'h33);

        // Random transfers against the model
        for (int t = 0; t < 20; t++) begin
            kind = $urandom_range(0, 3);
            n = $urandom_range(1, 4);
            p = 8'($urandom_range(0, 255));
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom_range(0, 255));
            case (kind)
                0: t_write(c_addr, p, n);
                1: t_ptr_read(p, n);
                2: t_read(n);
                default: t_write(7'($urandom_range(0, 127)) | 7'h40, p, n);
            endcase
        end
        for (int i = 0; i < c_depth; i++) check_host(i);

        // STOP after 5 bits of a data byte aborts the byte
        p0 = stop_cnt;
        bus_start();
        write_byte({c_addr, 1'b0}, ack); check("abort_addr_ack", ack, 1'b0);
        write_byte(8'h07, ack);          check("abort_ptr_ack", ack, 1'b0);
        model_ptr = 7;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        bus_stop();
        check("abort_stop", stop_cnt - p0, 1);
        check("abort_busy", busy, 1'b0);
        check("abort_hit", addr_hit, 1'b0);
        check_wr();
        t_read(1);

        // Reset during the 4th bit of a read
        wbuf[0] = 8'h00;
        t_write(c_addr, 8'h05, 1);
        bus_start();
        write_byte({c_addr, 1'b0}, ack); check("rr_addr_ack", ack, 1'b0);
        write_byte(8'h05, ack);          check("rr_ptr_ack", ack, 1'b0);
        bus_start();
        write_byte({c_addr, 1'b1}, ack); check("rr_raddr_ack", ack, 1'b0);
        for (int i = 0; i < 3; i++) get_bit(b);
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        check("oe_before_rst", sda_oe, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("oe_after_rst", sda_oe, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rr_busy", busy, 1'b0);
        for (int i = 0; i < c_depth; i++) model_mem[i] = 8'h00;
        model_ptr = 0;
        got_wr.delete();
        for (int i = 0; i < c_depth; i++) check_host(i);
        wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
        t_write(c_addr, 8'h02, 2);
        check_host(2);
        check_host(3);
        t_ptr_read(8'h02, 2);

        check("oe_while_scl_high", oe_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
